gray_ptr_sync_decoder: RTL
==========================

Name: gray_ptr_sync_decoder

Overview:
- Receiving end of the Gray-coded FIFO pointer crossing.
- Takes the remote write pointer, which arrives Gray-coded and asynchronous to this domain, and passes it through a multi-flop synchronizer.
- Decodes it to binary and compares it with the local read pointer to produce fill level, empty and almost-empty flags.
- Also monitors the crossing for illegal multi-bit Gray transitions and impossible occupancy. Sits in the read clock domain of the async FIFO, beside the read-side pointer counter.

Parameters:
- PTR_WIDTH, 8, pointer width including the wrap bit; FIFO depth = 2**(PTR_WIDTH-1).
- SYNC_STAGES, 2, synchronizer flop count, minimum 2.
- AE_THRESH, 4, almost_empty asserted when level <= AE_THRESH.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  asynchronous, active-high reset.
- wptr_gray_async  in  PTR_WIDTH  Gray write pointer from the remote domain, unsynchronized.
- rptr_gray  in  PTR_WIDTH  local Gray read pointer, registered on clk.
- err_clr  in  1  single-cycle clear for the sticky error flags.
- wptr_gray_sync  out  PTR_WIDTH  last synchronizer stage.
- wptr_bin  out  PTR_WIDTH  registered binary decode of wptr_gray_sync.
- level  out  PTR_WIDTH  registered occupancy, 0..2**(PTR_WIDTH-1).
- empty  out  1  registered, level==0.
- almost_empty  out  1  registered, level<=AE_THRESH.
- gray_err  out  1  sticky; a synchronized pointer changed by more than one bit.
- ovf_err  out  1  sticky; computed occupancy exceeded depth.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All flops clear on rst assertion.
- Reset values:
  - wptr_gray_sync = 0, wptr_bin = 0, level = 0.
  - empty = 1, almost_empty = 1.
  - gray_err = 0, ovf_err = 0.
  - Internal previous-sync register = 0.
- Synchronizer:
  - wptr_gray_async passes through SYNC_STAGES flops; the last stage drives wptr_gray_sync.
  - Latency is SYNC_STAGES clk edges from a stable input.
  - No logic is allowed between synchronizer stages.
- Decode stage, one registered cycle after wptr_gray_sync:
  - wptr_bin[MSB] = g[MSB]; wptr_bin[i] = g[i] ^ wptr_bin[i+1].
  - rptr_gray is decoded the same way, combinationally, from the value present at that edge.
- Level:
  - level = (wptr_bin_next - rptr_bin) mod 2**PTR_WIDTH, registered in the same cycle as wptr_bin.
  - Wrap-around is handled purely by modulo subtraction and the extra MSB.
  - Level == depth means full occupancy and is legal.
- Flags:
  - empty and almost_empty are computed from the new level value and registered alongside it, so all four decode outputs update on the same edge.
  - Total latency from async input to flags is SYNC_STAGES+1 cycles.
- Flag bias: flags are pessimistic by design. A stale write pointer only overstates emptiness, which is safe for the reader.
- gray_err:
  - On each edge, the current wptr_gray_sync is compared with the previous-sync register.
  - If their XOR has more than one bit set, gray_err is set.
  - The previous-sync register then loads wptr_gray_sync.
- ovf_err: set when the newly computed level exceeds 2**(PTR_WIDTH-1).
- Error clearing:
  - err_clr clears both sticky flags.
  - A new error detected in the same cycle as err_clr wins; the flag stays 1.
- Simultaneous events: rptr_gray and the write pointer changing in the same cycle needs no special case, because level is recomputed every cycle.
- Reset mid-operation: all state returns to reset values immediately. After deassertion, the first valid flags appear SYNC_STAGES+1 cycles after input is stable.

Test Plan:
- Reset: assert rst with arbitrary wptr_gray_async=8'h5A -> empty=1, almost_empty=1, level=0, wptr_bin=0, gray_err=0, ovf_err=0 while rst is high.
- Single write: rptr_gray=0, wptr_gray_async 8'h00->8'h01 -> after 3 clk, wptr_bin=1, level=1, empty=0, almost_empty=1. After 2 clk, wptr_gray_sync=8'h01.
- Gray ramp:
  - Stimulus: write Gray counts for binary 0..6, one per clk, with rptr_gray=0.
  - level follows 0..6 with a 3-cycle lag.
  - almost_empty drops on the cycle level becomes 5.
  - gray_err stays 0.
- Wrap and full:
  - wptr bin 130 (Gray 8'hC3) with rptr bin 5 (Gray 8'h07) -> level=125.
  - wptr bin 128 (Gray 8'hC0) with rptr 0 -> level=128, ovf_err=0.
  - wptr bin 129 (Gray 8'hC1) with rptr 0 -> level=129, ovf_err=1.
- Illegal transition:
  - Jump wptr_gray_async 8'h00->8'h03 -> gray_err=1, 3 cycles later, and it stays 1.
  - Pulse err_clr -> gray_err=0 next edge.
  - err_clr coincident with another 2-bit jump -> gray_err remains 1.
- Mid-run reset: at level=6, assert rst for 1 cycle -> all outputs return to reset values immediately. With wptr still 6, level=6 reappears 3 cycles after deassertion.

Source files
------------

// File: rtl/gray_ptr_sync_decoder.sv
// Read-domain receiver for a Gray-coded FIFO write pointer.
// The pointer goes through a plain flop synchronizer, then one registered
// decode stage turns it into binary and derives level, empty and
// almost_empty against the local read pointer. Two sticky monitors flag
// multi-bit Gray steps and impossible occupancy.
module gray_ptr_sync_decoder #(
    parameter int unsigned PTR_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_THRESH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PTR_WIDTH-1:0] wptr_gray_async,
    input  logic [PTR_WIDTH-1:0] rptr_gray,
    input  logic                 err_clr,
    output logic [PTR_WIDTH-1:0] wptr_gray_sync,
    output logic [PTR_WIDTH-1:0] wptr_bin,
    output logic [PTR_WIDTH-1:0] level,
    output logic                 empty,
    output logic                 almost_empty,
    output logic                 gray_err,
    output logic                 ovf_err
);

    localparam int unsigned          DEPTH   = 1 << (PTR_WIDTH - 1);
    localparam logic [PTR_WIDTH-1:0] DEPTH_W = PTR_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] AE_W    = PTR_WIDTH'(AE_THRESH);

    // Gray to binary: each binary bit is the XOR of all Gray bits above and at it.
    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b = g;
        for (int i = int'(PTR_WIDTH) - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][PTR_WIDTH-1:0] sync_q;
    logic [PTR_WIDTH-1:0]                  prev_sync_q;

    logic [PTR_WIDTH-1:0] wptr_bin_next;
    logic [PTR_WIDTH-1:0] rptr_bin;
    logic [PTR_WIDTH-1:0] level_next;
    logic [PTR_WIDTH-1:0] gray_diff;
    logic                 gray_jump;
    logic                 ovf_detect;

    // Synchronizer chain: straight flop-to-flop, nothing between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= wptr_gray_async;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wptr_gray_sync = sync_q[SYNC_STAGES-1];

    // Decode both pointers; modulo subtraction with the wrap bit gives occupancy.
    always_comb begin
        wptr_bin_next = gray2bin(wptr_gray_sync);
        rptr_bin      = gray2bin(rptr_gray);
        level_next    = wptr_bin_next - rptr_bin;
        gray_diff     = wptr_gray_sync ^ prev_sync_q;
        gray_jump     = (gray_diff & (gray_diff - PTR_WIDTH'(1))) != '0;
        ovf_detect    = level_next > DEPTH_W;
    end

    // Decode outputs all update on the same edge; reset reads as empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_bin     <= '0;
            level        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            wptr_bin     <= wptr_bin_next;
            level        <= level_next;
            empty        <= level_next == '0;
            almost_empty <= level_next <= AE_W;
        end
    end

    // Sticky error monitors; a fresh detection outranks a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sync_q <= '0;
            gray_err    <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            prev_sync_q <= wptr_gray_sync;
            if (err_clr) begin
                gray_err <= gray_jump;
                ovf_err  <= ovf_detect;
            end else begin
                gray_err <= gray_err | gray_jump;
                ovf_err  <= ovf_err | ovf_detect;
            end
        end
    end

endmodule
